// File: rtl/mext_pkg.sv
// Shared definitions for the M-extension sequencing wrapper: funct3 codes,
// FSM states, operand sign encodings and result-source selection.
package mext_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // bit0 = operand A signed, bit1 = operand B signed
    localparam logic [1:0] SGN_UU = 2'b00;
    localparam logic [1:0] SGN_SU = 2'b01;
    localparam logic [1:0] SGN_SS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_LSB = 2'd0,
        SRC_MSB = 2'd1,
        SRC_QUO = 2'd2,
        SRC_REM = 2'd3
    } src_e;

    function automatic logic [1:0] f3_sign(input logic [2:0] f3);
        logic [1:0] sgn;
        unique case (f3)
            F3_MULH, F3_DIV, F3_REM: sgn = SGN_SS;
            F3_MULHSU:               sgn = SGN_SU;
            default:                 sgn = SGN_UU;
        endcase
        return sgn;
    endfunction

    function automatic src_e f3_src(input logic [2:0] f3);
        src_e src;
        unique case (f3)
            F3_MUL:                      src = SRC_LSB;
            F3_MULH, F3_MULHSU, F3_MULHU: src = SRC_MSB;
            F3_DIV, F3_DIVU:             src = SRC_QUO;
            default:                     src = SRC_REM;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/mext_special.sv
// Detects RISC-V divide-by-zero and signed-overflow div/rem cases and
// produces their architecturally defined result without using the core.
module mext_special
    import mext_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    output logic        is_special,
    output logic [31:0] special_result
);

    logic div_op;
    logic want_rem;
    logic by_zero;
    logic overflow;

    always_comb begin
        div_op         = funct3[2];
        want_rem       = funct3[1];
        by_zero        = (b == 32'd0);
        overflow       = (f3_sign(funct3) == SGN_SS) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        is_special     = div_op && (by_zero || overflow);
        special_result = '0;
        if (by_zero) begin
            special_result = want_rem ? a : 32'hFFFF_FFFF;
        end else if (overflow) begin
            special_result = want_rem ? 32'd0 : 32'h8000_0000;
        end
    end

endmodule

// File: rtl/mext_seq_ctrl.sv
// Sequencer around the combinational RV32M mul/div core: accepts one op,
// waits the settle time, registers the selected result. Optional macro
// MEXT_DIV_REUSE_EN adds a one-entry cache of the last div/rem operands.
module mext_seq_ctrl
    import mext_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        busy,
    output logic        core_mul_en,
    output logic        core_div_en,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic [1:0]  core_sign,
    input  logic [31:0] core_ab_msb,
    input  logic [31:0] core_ab_lsb,
    input  logic [31:0] core_quo,
    input  logic [31:0] core_rem
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    state_e      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] a_q, b_q, res_q, res_nxt;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        accept;
    logic        exec;
    logic        is_special;
    logic [31:0] special_result;
    logic        reuse_hit;
    logic [31:0] reuse_result;
    logic [31:0] core_sel;

    mext_special u_special (
        .a              (in_rs1),
        .b              (in_rs2),
        .funct3         (in_funct3),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign accept = (state == IDLE) && in_valid && !flush;
    assign exec   = (state == EXEC);

    always_comb begin
        unique case (f3_src(f3_q))
            SRC_LSB: core_sel = core_ab_lsb;
            SRC_MSB: core_sel = core_ab_msb;
            SRC_QUO: core_sel = core_quo;
            default: core_sel = core_rem;
        endcase
    end

`ifdef MEXT_DIV_REUSE_EN
    logic        ru_vld;
    logic        ru_signed;
    logic [31:0] ru_a, ru_b, ru_quo, ru_rem;
    logic        store_ru;

    // Only a div/rem that actually ran to completion on the core refreshes the entry
    assign store_ru = exec && (cnt == 4'd0) && f3_q[2] && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ru_vld    <= 1'b0;
            ru_signed <= 1'b0;
            ru_a      <= '0;
            ru_b      <= '0;
            ru_quo    <= '0;
            ru_rem    <= '0;
        end else if (store_ru) begin
            ru_vld    <= 1'b1;
            ru_signed <= (f3_sign(f3_q) == SGN_SS);
            ru_a      <= a_q;
            ru_b      <= b_q;
            ru_quo    <= core_quo;
            ru_rem    <= core_rem;
        end
    end

    assign reuse_hit    = ru_vld && in_funct3[2] && (in_rs1 == ru_a) && (in_rs2 == ru_b)
                          && (ru_signed == (f3_sign(in_funct3) == SGN_SS));
    assign reuse_result = in_funct3[1] ? ru_rem : ru_quo;
`else
    assign reuse_hit    = 1'b0;
    assign reuse_result = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            f3_q  <= '0;
            rd_q  <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            res_q <= res_nxt;
            if (accept) begin
                a_q  <= in_rs1;
                b_q  <= in_rs2;
                f3_q <= in_funct3;
                rd_q <= in_rd;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        res_nxt   = res_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (is_special) begin
                        res_nxt   = special_result;
                        state_nxt = DONE;
                    end else if (reuse_hit) begin
                        res_nxt   = reuse_result;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = in_funct3[2] ? DIV_LOAD : MUL_LOAD;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    res_nxt   = core_sel;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A kill overrides everything, including a completing or waiting result
        if (flush) begin
            state_nxt = IDLE;
            res_nxt   = res_q;
        end
    end

    // Outside EXEC the core sees benign operands (0 / 1) so it never divides by zero
    assign core_mul_en = exec && !f3_q[2];
    assign core_div_en = exec && f3_q[2];
    assign core_a      = exec ? a_q : 32'd0;
    assign core_b      = exec ? b_q : 32'd1;
    assign core_sign   = exec ? f3_sign(f3_q) : SGN_UU;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_result = res_q;
    assign out_rd     = rd_q;

endmodule

// File: tb/tb_mext_seq_ctrl.sv
// Self-checking bench for mext_seq_ctrl: directed cases plus randomized ops
// against an arithmetic RV32M reference model; honours MEXT_DIV_REUSE_EN.
module tb_mext_seq_ctrl;

    localparam int MUL_N = 2;
    localparam int DIV_N = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;
    logic        core_mul_en;
    logic        core_div_en;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [1:0]  core_sign;
    logic [31:0] core_ab_msb;
    logic [31:0] core_ab_lsb;
    logic [31:0] core_quo;
    logic [31:0] core_rem;

    int compared   = 0;
    int mismatched = 0;

    // Reference view of the optional div/rem reuse entry
    bit          reuse_enabled;
    bit          ru_vld;
    bit          ru_signed;
    logic [31:0] ru_a, ru_b;

    mext_seq_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .busy        (busy),
        .core_mul_en (core_mul_en),
        .core_div_en (core_div_en),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_sign   (core_sign),
        .core_ab_msb (core_ab_msb),
        .core_ab_lsb (core_ab_lsb),
        .core_quo    (core_quo),
        .core_rem    (core_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational core model; outputs are poisoned unless the matching enable is high
    logic signed [63:0] cm_a, cm_b, cm_p, cm_q, cm_r;
    always_comb begin
        cm_a = core_sign[0] ? {{32{core_a[31]}}, core_a} : {32'd0, core_a};
        cm_b = core_sign[1] ? {{32{core_b[31]}}, core_b} : {32'd0, core_b};
        cm_p = cm_a * cm_b;
        cm_q = '0;
        cm_r = '0;
        if (core_b != 32'd0) begin
            cm_q = cm_a / cm_b;
            cm_r = cm_a % cm_b;
        end
        core_ab_msb = core_mul_en ? cm_p[63:32] : 32'hDEAD_BEEF;
        core_ab_lsb = core_mul_en ? cm_p[31:0]  : 32'hDEAD_BEEF;
        core_quo    = (core_div_en && core_b != 32'd0) ? cm_q[31:0] : 32'hDEAD_BEEF;
        core_rem    = (core_div_en && core_b != 32'd0) ? cm_r[31:0] : 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        r  = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic bit ref_signed_div(input logic [2:0] f3);
        return (f3 == 3'd4) || (f3 == 3'd6);
    endfunction

    function automatic logic [1:0] ref_sign(input logic [2:0] f3);
        if (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) return 2'b11;
        if (f3 == 3'd2) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || (ref_signed_div(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic bit ref_reuse(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return reuse_enabled && ru_vld && f3[2] && a == ru_a && b == ru_b && ru_signed == ref_signed_div(f3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, follow it to completion, hold the result for 'hold' cycles, then retire it.
    // Latency is counted in edges after the accepting edge: 0 for shortcut ops (result at
    // the accepting edge itself), N for ops that run on the core.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input int hold);
        logic [31:0] exp;
        bit          shortcut;
        int          exp_lat, lat, mul_cnt, div_cnt;
        exp      = ref_result(f3, a, b);
        shortcut = ref_special(f3, a, b) || ref_reuse(f3, a, b);
        exp_lat  = shortcut ? 0 : (f3[2] ? DIV_N : MUL_N);
        @(negedge clk);
        checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_rs1    = a;
        in_rs2    = b;
        in_rd     = rd;
        @(negedge clk);
        in_valid = 1'b0;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        lat      = 0;
        mul_cnt  = 0;
        div_cnt  = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            if (core_mul_en === 1'b1) mul_cnt++;
            if (core_div_en === 1'b1) div_cnt++;
            if (lat == 0) begin
                checkOutput("exec_in_ready", {31'd0, in_ready}, 32'd0);
                checkOutput("core_a", core_a, a);
                checkOutput("core_b", core_b, b);
                checkOutput("core_sign", {30'd0, core_sign}, {30'd0, ref_sign(f3)});
            end
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, exp_lat);
        checkOutput("mul_en_cycles", mul_cnt, (!shortcut && !f3[2]) ? MUL_N : 0);
        checkOutput("div_en_cycles", div_cnt, (!shortcut && f3[2]) ? DIV_N : 0);
        checkOutput("result", out_result, exp);
        checkOutput("out_rd", {27'd0, out_rd}, {27'd0, rd});
        if (!shortcut && f3[2]) begin
            ru_vld    = 1'b1;
            ru_a      = a;
            ru_b      = b;
            ru_signed = ref_signed_div(f3);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_result", out_result, exp);
            checkOutput("hold_rd", {27'd0, out_rd}, {27'd0, rd});
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("hold_enables", {30'd0, core_mul_en, core_div_en}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("retired_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("retired_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        reuse_enabled = 1'b0;
`ifdef MEXT_DIV_REUSE_EN
        reuse_enabled = 1'b1;
`endif
        ru_vld    = 1'b0;
        ru_signed = 1'b0;
        ru_a      = '0;
        ru_b      = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_funct3 = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_outs", {27'd0, out_valid, busy, core_mul_en, core_div_en, 1'b0}, 32'd0);
        checkOutput("reset_sign", {30'd0, core_sign}, 32'd0);
        checkOutput("reset_result", out_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        applyStimulus(3'd0, 32'd7, 32'd6, 5'd3, 0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 1);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0);
        applyStimulus(3'd7, 32'd5, 32'd0, 5'd6, 0);
        applyStimulus(3'd5, 32'd100, 32'd7, 5'd7, 3);
        applyStimulus(3'd4, 32'd100, 32'd7, 5'd8, 0);
        applyStimulus(3'd6, 32'd100, 32'd7, 5'd9, 0);

        // Flush in the second EXEC cycle of a DIV: abort, no result, entry not refreshed
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'd4; in_rs1 = 32'd1000; in_rs2 = 32'd9; in_rd = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_exec_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_exec_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_exec_div_en", {31'd0, core_div_en}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("flush_exec_quiet", {31'd0, out_valid}, 32'd0);
        applyStimulus(3'd4, 32'd1000, 32'd9, 5'd11, 0);

        // Flush coinciding with in_valid: op must not be accepted
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'd0; in_rs1 = 32'd3; in_rs2 = 32'd3;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_accept_busy", {31'd0, busy}, 32'd0);

        // Flush while a result waits in DONE discards it
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'd7; in_rs1 = 32'd77; in_rs2 = 32'd0; in_rd = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("done_before_flush", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_done_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_done_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'd0; in_rs1 = 32'd9; in_rs2 = 32'd9; in_rd = 5'd13;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy_en", {29'd0, busy, core_mul_en, core_div_en}, 32'd0);
        checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("arst_result", out_result, 32'd0);
        checkOutput("arst_rd", {27'd0, out_rd}, 32'd0);
        ru_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized ops, biased toward the div/rem corner operands and repeated operands
        a = 32'd0;
        b = 32'd1;
        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = 32'hFFFF_FFFF;
                    2: b = 32'($urandom_range(1, 20));
                    default: b = $urandom;
                endcase
            end
            applyStimulus(f3, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
